// File: rtl/any1_writeback_arbiter_if.sv
// Result-source and writeback bus bundle for any1_writeback_arbiter.
// The master modport is the functional-unit/ROB side; the slave modport is the arbiter.
interface any1_writeback_arbiter_if #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned WID  = 64,
  parameter int unsigned RIDW = 6
);
  localparam int unsigned SW = $clog2(NSRC);

  logic [NSRC-1:0]      src_v_i;
  logic [NSRC*RIDW-1:0] src_rid_i;
  logic [NSRC*WID-1:0]  src_res_i;
  logic [NSRC*8-1:0]    src_exc_i;
  logic [NSRC-1:0]      src_rdy_o;
  logic                 wb_v_o;
  logic [RIDW-1:0]      wb_rid_o;
  logic [WID-1:0]       wb_res_o;
  logic [7:0]           wb_exc_o;
  logic [SW-1:0]        wb_src_o;
  logic                 busy_o;

  modport master (
    output src_v_i, src_rid_i, src_res_i, src_exc_i,
    input  src_rdy_o, wb_v_o, wb_rid_o, wb_res_o, wb_exc_o, wb_src_o, busy_o
  );

  modport slave (
    input  src_v_i, src_rid_i, src_res_i, src_exc_i,
    output src_rdy_o, wb_v_o, wb_rid_o, wb_res_o, wb_exc_o, wb_src_o, busy_o
  );
endinterface

// File: rtl/any1_writeback_arbiter.sv
// Collects functional-unit results into per-source FIFOs and serialises them, round-robin,
// onto a single registered ROB writeback/wakeup bus at one result per clock.
module any1_writeback_arbiter #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned WID   = 64,
  parameter int unsigned RIDW  = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  any1_writeback_arbiter_if.slave io
);
  localparam int unsigned SW = $clog2(NSRC);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [RIDW-1:0] rid_mem_q [NSRC][DEPTH];
  logic [RIDW-1:0] rid_mem_d [NSRC][DEPTH];
  logic [WID-1:0]  res_mem_q [NSRC][DEPTH];
  logic [WID-1:0]  res_mem_d [NSRC][DEPTH];
  logic [7:0]      exc_mem_q [NSRC][DEPTH];
  logic [7:0]      exc_mem_d [NSRC][DEPTH];
  logic [PW-1:0]   wr_ptr_q  [NSRC];
  logic [PW-1:0]   wr_ptr_d  [NSRC];
  logic [PW-1:0]   rd_ptr_q  [NSRC];
  logic [PW-1:0]   rd_ptr_d  [NSRC];
  logic [CW-1:0]   cnt_q     [NSRC];
  logic [CW-1:0]   cnt_d     [NSRC];

  logic [SW-1:0]   last_q, last_d;
  logic            wb_v_q, wb_v_d;
  logic [RIDW-1:0] wb_rid_q, wb_rid_d;
  logic [WID-1:0]  wb_res_q, wb_res_d;
  logic [7:0]      wb_exc_q, wb_exc_d;
  logic [SW-1:0]   wb_src_q, wb_src_d;

  logic [NSRC-1:0] req, rdy, push, pop;
  logic [SW-1:0]   grant;
  logic            gnt_v;

  always_comb begin
    req = '0;
    rdy = '0;
    for (int i = 0; i < NSRC; i++) begin
      req[i] = (cnt_q[i] != '0);
      rdy[i] = (cnt_q[i] != CW'(DEPTH));
    end
  end

  // Scan starts just after the last winner so every requester is reached within NSRC grants.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    gnt_v = 1'b0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      idx = (int'(last_q) + k) % NSRC;
      if (!gnt_v && req[idx]) begin
        gnt_v = 1'b1;
        grant = SW'(idx);
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NSRC; i++) begin
      push[i] = io.src_v_i[i] && rdy[i] && !flush_i;
    end
    if (gnt_v && !flush_i) pop[grant] = 1'b1;
  end

  always_comb begin
    rid_mem_d = rid_mem_q;
    res_mem_d = res_mem_q;
    exc_mem_d = exc_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    wb_v_d    = gnt_v && !flush_i;
    wb_rid_d  = wb_rid_q;
    wb_res_d  = wb_res_q;
    wb_exc_d  = wb_exc_q;
    wb_src_d  = wb_src_q;

    for (int i = 0; i < NSRC; i++) begin
      if (flush_i) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (push[i]) begin
          rid_mem_d[i][wr_ptr_q[i]] = io.src_rid_i[i*RIDW +: RIDW];
          res_mem_d[i][wr_ptr_q[i]] = io.src_res_i[i*WID +: WID];
          exc_mem_d[i][wr_ptr_q[i]] = io.src_exc_i[i*8 +: 8];
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
        end
        if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end

    if (wb_v_d) begin
      wb_rid_d = rid_mem_q[grant][rd_ptr_q[grant]];
      wb_res_d = res_mem_q[grant][rd_ptr_q[grant]];
      wb_exc_d = exc_mem_q[grant][rd_ptr_q[grant]];
      wb_src_d = grant;
      last_d   = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          rid_mem_q[i][j] <= '0;
          res_mem_q[i][j] <= '0;
          exc_mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      last_q   <= SW'(NSRC - 1);
      wb_v_q   <= 1'b0;
      wb_rid_q <= '0;
      wb_res_q <= '0;
      wb_exc_q <= '0;
      wb_src_q <= '0;
    end else begin
      rid_mem_q <= rid_mem_d;
      res_mem_q <= res_mem_d;
      exc_mem_q <= exc_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      wb_v_q    <= wb_v_d;
      wb_rid_q  <= wb_rid_d;
      wb_res_q  <= wb_res_d;
      wb_exc_q  <= wb_exc_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign io.src_rdy_o = rdy;
  assign io.wb_v_o    = wb_v_q;
  assign io.wb_rid_o  = wb_rid_q;
  assign io.wb_res_o  = wb_res_q;
  assign io.wb_exc_o  = wb_exc_q;
  assign io.wb_src_o  = wb_src_q;
  assign io.busy_o    = (|req) || wb_v_q;
endmodule

// File: tb/tb_any1_writeback_arbiter.sv
// Directed self-checking bench for any1_writeback_arbiter with four sources, FIFO depth 2.
module tb_any1_writeback_arbiter;
  localparam int unsigned NSRC  = 4;
  localparam int unsigned WID   = 64;
  localparam int unsigned RIDW  = 6;
  localparam int unsigned DEPTH = 2;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic flush_i = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  any1_writeback_arbiter_if #(.NSRC(NSRC), .WID(WID), .RIDW(RIDW)) bus ();

  any1_writeback_arbiter #(.NSRC(NSRC), .WID(WID), .RIDW(RIDW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush_i),
    .io     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_src();
    bus.src_v_i   = '0;
    bus.src_rid_i = '0;
    bus.src_res_i = '0;
    bus.src_exc_i = '0;
  endtask

  task automatic set_src(input int i, input logic [RIDW-1:0] rid, input logic [WID-1:0] res,
                         input logic [7:0] exc);
    bus.src_v_i[i]               = 1'b1;
    bus.src_rid_i[i*RIDW +: RIDW] = rid;
    bus.src_res_i[i*WID +: WID]   = res;
    bus.src_exc_i[i*8 +: 8]       = exc;
  endtask

  task automatic do_reset();
    idle_src();
    flush_i = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.wb_v_o !== 1'b0) begin
      errors++; $display("FAIL reset_wb_v: got %0b expected 0", bus.wb_v_o);
    end
    checks++;
    if ({bus.wb_rid_o, bus.wb_res_o, bus.wb_exc_o, bus.wb_src_o} !== '0) begin
      errors++; $display("FAIL reset_wb_fields: got rid=%0h res=%0h exc=%0h src=%0h expected 0",
                         bus.wb_rid_o, bus.wb_res_o, bus.wb_exc_o, bus.wb_src_o);
    end
    checks++;
    if (bus.src_rdy_o !== 4'hF) begin
      errors++; $display("FAIL reset_rdy: got %0h expected f", bus.src_rdy_o);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy_o);
    end
  endtask

  task automatic test_latency();
    do_reset();
    set_src(0, 6'd5, 64'hAA, 8'h00);
    tick();
    idle_src();
    checks++;
    if (bus.wb_v_o !== 1'b0) begin
      errors++; $display("FAIL lat_early: got wb_v=%0b expected 0", bus.wb_v_o);
    end
    tick();
    checks++;
    if (bus.wb_v_o !== 1'b1 || bus.wb_rid_o !== 6'd5 || bus.wb_res_o !== 64'hAA ||
        bus.wb_src_o !== 2'd0 || bus.wb_exc_o !== 8'h00) begin
      errors++; $display("FAIL lat_wb: got v=%0b rid=%0d res=%0h src=%0d exc=%0h expected 1 5 aa 0 0",
                         bus.wb_v_o, bus.wb_rid_o, bus.wb_res_o, bus.wb_src_o, bus.wb_exc_o);
    end
    tick();
    checks++;
    if (bus.wb_v_o !== 1'b0 || bus.wb_rid_o !== 6'd5 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL lat_after: got v=%0b rid=%0d busy=%0b expected 0 5 0",
                         bus.wb_v_o, bus.wb_rid_o, bus.busy_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(10 + i), 64'(256 + i), 8'(i + 1));
    tick();
    idle_src();
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (bus.wb_v_o !== 1'b1 || bus.wb_rid_o !== 6'(10 + j) || bus.wb_src_o !== 2'(j) ||
          bus.wb_res_o !== 64'(256 + j) || bus.wb_exc_o !== 8'(j + 1)) begin
        errors++; $display("FAIL rr_%0d: got v=%0b rid=%0d src=%0d res=%0h exc=%0h expected 1 %0d %0d %0h %0h",
                           j, bus.wb_v_o, bus.wb_rid_o, bus.wb_src_o, bus.wb_res_o, bus.wb_exc_o,
                           10 + j, j, 256 + j, j + 1);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0] exp_rdy;
    int         nxt;
    int         seen;
    logic       pushed;
    exp_rdy = 4'b1001;  // bit c is src_rdy_o[2] expected in cycle c (c = 1..4), read MSB-first
    nxt  = 0;
    seen = 0;
    do_reset();
    for (int cyc = 0; cyc < 28; cyc++) begin
      if (cyc < 20) begin
        set_src(0, 6'd1, 64'h1, 8'h0);
        set_src(1, 6'd2, 64'h2, 8'h0);
        set_src(3, 6'd3, 64'h3, 8'h0);
      end else begin
        idle_src();
      end
      if (nxt < 3) set_src(2, 6'(20 + nxt), 64'(32'hC0 + nxt), 8'h0);
      else bus.src_v_i[2] = 1'b0;
      if (cyc >= 1 && cyc <= 4) begin
        checks++;
        if (bus.src_rdy_o[2] !== exp_rdy[4 - cyc]) begin
          errors++; $display("FAIL bp_rdy2_cyc%0d: got %0b expected %0b",
                             cyc, bus.src_rdy_o[2], exp_rdy[4 - cyc]);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (nxt !== 2) begin
          errors++; $display("FAIL bp_third_early: got accepted=%0d expected 2", nxt);
        end
      end
      pushed = bus.src_v_i[2] && bus.src_rdy_o[2];
      tick();
      if (pushed) nxt++;
      if (bus.wb_v_o === 1'b1 && bus.wb_src_o === 2'd2) begin
        checks++;
        if (seen >= 3 || bus.wb_rid_o !== 6'(20 + seen) || bus.wb_res_o !== 64'(32'hC0 + seen)) begin
          errors++; $display("FAIL bp_src2_wb%0d: got rid=%0d res=%0h expected rid=%0d",
                             seen, bus.wb_rid_o, bus.wb_res_o, 20 + seen);
        end
        seen++;
      end
    end
    checks++;
    if (seen !== 3) begin
      errors++; $display("FAIL bp_src2_count: got %0d expected 3", seen);
    end
  endtask

  task automatic test_flush();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(30 + i), 64'(30 + i), 8'h0);
    tick();
    tick();
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_pre_busy: got %0b expected 1", bus.busy_o);
    end
    idle_src();
    set_src(1, 6'd40, 64'h40, 8'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    idle_src();
    checks++;
    if (bus.wb_v_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_state: got wb_v=%0b busy=%0b expected 0 0", bus.wb_v_o, bus.busy_o);
    end
    checks++;
    if (bus.src_rdy_o !== 4'hF) begin
      errors++; $display("FAIL flush_rdy: got %0h expected f", bus.src_rdy_o);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.wb_v_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL flush_no_wb: got %0d writebacks (last rid=%0d) expected 0",
                         bad, bus.wb_rid_o);
    end
    // Last winner before the flush was source 0, so source 1 now goes ahead of source 0.
    set_src(0, 6'd41, 64'h41, 8'h0);
    set_src(1, 6'd42, 64'h42, 8'h0);
    tick();
    idle_src();
    tick();
    checks++;
    if (bus.wb_v_o !== 1'b1 || bus.wb_src_o !== 2'd1 || bus.wb_rid_o !== 6'd42) begin
      errors++; $display("FAIL flush_last_kept: got v=%0b src=%0d rid=%0d expected 1 1 42",
                         bus.wb_v_o, bus.wb_src_o, bus.wb_rid_o);
    end
    tick();
  endtask

  task automatic test_fairness();
    int cnt [4];
    int h1, h2, h3;
    int gaps, rep;
    gaps = 0;
    rep  = 0;
    h1   = -1;
    h2   = -1;
    h3   = -1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(50 + i), 64'(50 + i), 8'h0);
    tick();
    tick();
    for (int n = 0; n < 40; n++) begin
      if (bus.wb_v_o !== 1'b1) begin
        gaps++;
      end else begin
        cnt[bus.wb_src_o]++;
        if (int'(bus.wb_src_o) == h1 || int'(bus.wb_src_o) == h2 || int'(bus.wb_src_o) == h3) rep++;
        h3 = h2;
        h2 = h1;
        h1 = int'(bus.wb_src_o);
      end
      tick();
    end
    idle_src();
    checks++;
    if (gaps !== 0) begin
      errors++; $display("FAIL fair_gaps: got %0d idle cycles expected 0", gaps);
    end
    checks++;
    if (rep !== 0) begin
      errors++; $display("FAIL fair_repeat: got %0d repeats within 4 expected 0", rep);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] !== 10) begin
        errors++; $display("FAIL fair_count_src%0d: got %0d expected 10", i, cnt[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(16 + i), 64'(16 + i), 8'h0);
    tick();
    idle_src();
    tick();
    checks++;
    if (bus.wb_v_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL ares_pre: got wb_v=%0b busy=%0b expected 1 1", bus.wb_v_o, bus.busy_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wb_v_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.src_rdy_o !== 4'hF) begin
      errors++; $display("FAIL ares_immediate: got wb_v=%0b busy=%0b rdy=%0h expected 0 0 f",
                         bus.wb_v_o, bus.busy_o, bus.src_rdy_o);
    end
    #1;
    rst_n = 1'b1;
    set_src(0, 6'd60, 64'h60, 8'h0);
    set_src(3, 6'd63, 64'h63, 8'h0);
    tick();
    idle_src();
    tick();
    checks++;
    if (bus.wb_v_o !== 1'b1 || bus.wb_src_o !== 2'd0 || bus.wb_rid_o !== 6'd60) begin
      errors++; $display("FAIL ares_first_grant: got v=%0b src=%0d rid=%0d expected 1 0 60",
                         bus.wb_v_o, bus.wb_src_o, bus.wb_rid_o);
    end
    tick();
    checks++;
    if (bus.wb_v_o !== 1'b1 || bus.wb_src_o !== 2'd3 || bus.wb_rid_o !== 6'd63) begin
      errors++; $display("FAIL ares_second_grant: got v=%0b src=%0d rid=%0d expected 1 3 63",
                         bus.wb_v_o, bus.wb_src_o, bus.wb_rid_o);
    end
  endtask

  initial begin
    idle_src();
    test_reset();
    test_latency();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_fairness();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
